// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: default 640x480@60 timing constants, total-period helpers and receiver state encoding.
package vga_rx_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned PIX_DLY_DEF  = 1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_e;

  function automatic int unsigned h_tot(input int unsigned act, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_tot(input int unsigned act, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: samples a sync line on pixel ticks and flags a 1->0 transition on the sampling tick.
module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic p_tick,
  input  logic sync_in,
  output logic fall
);

  logic sync_q, sync_d;

  always_comb begin
    sync_d = sync_q;
    if (p_tick) sync_d = sync_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 1'b1;
    else        sync_q <= sync_d;
  end

  assign fall = p_tick & sync_q & ~sync_in;

endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: locks to VGA sync timing, recovers active pixels/coordinates, flags timing faults.
// Defining VGA_RX_CHECKSUM_EN adds a per-frame 16-bit wrapping sum of active pixels on frame_sum.
module vga_sync_receiver
  import vga_rx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned PIX_DLY  = PIX_DLY_DEF
) (
  input  logic        clk_100Mhz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines,
  output logic        timing_err,
  output logic [15:0] frame_sum
);

  localparam logic [9:0] H_TOT_L = 10'(h_tot(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam logic [9:0] V_TOT_L = 10'(v_tot(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam logic [9:0] H0      = 10'(H_SYNC + H_BP + PIX_DLY);
  localparam logic [9:0] V0      = 10'(V_SYNC + V_BP);
  localparam logic [9:0] H_W     = 10'(H_ACTIVE);
  localparam logic [9:0] V_W     = 10'(V_ACTIVE);

  logic      hs_fall, vs_fall;
  rx_state_e state_q, state_d;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0]  line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic [9:0]  x_q, x_d, y_q, y_d, x_off, y_off;
  logic [11:0] pix_rgb_q, pix_rgb_d;
  logic        bad_q, bad_d;
  logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d, timing_err_q, timing_err_d;
  logic        line_bad, frame_bad, timeout, in_win;

  vga_sync_edge u_hs_edge (.clk(clk_100Mhz), .rst_n(reset_n), .p_tick(p_tick), .sync_in(hsync), .fall(hs_fall));
  vga_sync_edge u_vs_edge (.clk(clk_100Mhz), .rst_n(reset_n), .p_tick(p_tick), .sync_in(vsync), .fall(vs_fall));

  // Window and timeout use the post-update counts so hcnt==0 on the hsync-fall tick itself.
  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    bad_d         = bad_q;
    x_d           = x_q;
    y_d           = y_q;
    pix_rgb_d     = pix_rgb_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    timing_err_d  = 1'b0;
    line_bad      = 1'b0;
    frame_bad     = 1'b0;
    timeout       = 1'b0;
    in_win        = 1'b0;
    x_off         = '0;
    y_off         = '0;
    if (p_tick) begin
      if (vs_fall || hs_fall)  hcnt_d = '0;
      else if (hcnt_q != '1)   hcnt_d = hcnt_q + 1'b1;
      if (vs_fall)                     vcnt_d = '0;
      else if (hs_fall && vcnt_q != '1) vcnt_d = vcnt_q + 1'b1;
      if (hs_fall) line_len_d    = hcnt_q + 1'b1;
      if (vs_fall) frame_lines_d = vcnt_q + 1'b1;

      line_bad  = hs_fall && (line_len_d != H_TOT_L);
      frame_bad = vs_fall && (frame_lines_d != V_TOT_L);
      timeout   = (hcnt_d == '1);

      unique case (state_q)
        SEARCH: begin
          if (vs_fall) begin
            state_d = MEASURE;
            bad_d   = 1'b0;
          end
        end
        MEASURE: begin
          if (line_bad) bad_d = 1'b1;
          if (vs_fall) begin
            state_d = (!bad_q && !line_bad && !frame_bad) ? LOCKED : MEASURE;
            bad_d   = 1'b0;
          end
        end
        LOCKED: begin
          // A fault mid-frame leaves a partial frame, so the first re-measure frame is discarded.
          if (line_bad || frame_bad) begin
            timing_err_d = 1'b1;
            state_d      = MEASURE;
            bad_d        = !vs_fall;
          end
        end
        default: state_d = SEARCH;
      endcase

      if (timeout) begin
        state_d = SEARCH;
        if (state_q == LOCKED) timing_err_d = 1'b1;
      end

      if (vs_fall && state_q == LOCKED) frame_start_d = 1'b1;

      x_off  = hcnt_d - H0;
      y_off  = vcnt_d - V0;
      in_win = (hcnt_d >= H0) && (x_off < H_W) && (vcnt_d >= V0) && (y_off < V_W);
      if (state_q == LOCKED && in_win) begin
        pix_valid_d = 1'b1;
        x_d         = x_off;
        y_d         = y_off;
        pix_rgb_d   = rgb;
      end
    end
  end

  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEARCH;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      bad_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pix_rgb_q     <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      bad_q         <= bad_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_rgb_q     <= pix_rgb_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      timing_err_q  <= timing_err_d;
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] acc_q, acc_d, frame_sum_q, frame_sum_d;

  always_comb begin
    acc_d       = acc_q;
    frame_sum_d = frame_sum_q;
    if (vs_fall) begin
      if (state_q == LOCKED) frame_sum_d = acc_q;
      acc_d = '0;
    end else if (pix_valid_d) begin
      acc_d = acc_q + {4'b0000, rgb};
    end
  end

  always_ff @(posedge clk_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      frame_sum_q <= '0;
    end else begin
      acc_q       <= acc_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = '0;
`endif

  assign locked      = (state_q == LOCKED);
  assign pix_valid   = pix_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_start = frame_start_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign timing_err  = timing_err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced raster; pixel expectations go through a scoreboard queue.
module tb_vga_sync_receiver;

  localparam int HA = 16, HF = 4, HS = 8, HB = 6;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int PD = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int H0 = HS + HB + PD;
  localparam int V0 = VS + VB;
`ifdef VGA_RX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, p_tick, hsync, vsync;
  logic [11:0] rgb;
  logic        locked, pix_valid, frame_start, timing_err;
  logic [9:0]  x, y, line_len, frame_lines;
  logic [11:0] pix_rgb;
  logic [15:0] frame_sum;

  logic [31:0] exp_q[$];
  int          checks = 0, errors = 0;
  int          pv_cnt = 0, red_cnt = 0, err_cnt = 0, fs_cnt = 0;
  logic [15:0] sum_exp, s2, s3, s6;
  int          pv0, red0;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIX_DLY(PD)
  ) dut (
    .clk_100Mhz(clk), .reset_n(rst_n), .p_tick(p_tick), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .locked(locked), .pix_valid(pix_valid), .x(x), .y(y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .line_len(line_len), .frame_lines(frame_lines),
    .timing_err(timing_err), .frame_sum(frame_sum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_sum(input logic [15:0] s);
    return CSUM_EN ? s : 16'h0000;
  endfunction

  function automatic logic [11:0] pix_color(input int mode, input int col, input int row);
    case (mode)
      0:       return (col == 0 && row == 0) ? 12'hF00 : 12'h000;
      1:       return 12'((col * 37 + row * 211 + 5) % 4096);
      default: return 12'h001;
    endcase
  endfunction

  always @(negedge clk) begin
    if (pix_valid) begin
      pv_cnt++;
      if (pix_rgb == 12'hF00) red_cnt++;
      chk("pix_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("pix_xy_rgb", {x, y, pix_rgb}, exp_q.pop_front());
    end
    if (timing_err)  err_cnt++;
    if (frame_start) fs_cnt++;
  end

  task automatic tick(input logic hs, input logic vs, input logic [11:0] c);
    @(negedge clk);
    p_tick = 1'b1; hsync = hs; vsync = vs; rgb = c;
    @(negedge clk);
    p_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_line(input int l, input int mode, input bit push, input int extra);
    for (int t = 0; t < HT + extra; t++) begin
      int col, row;
      logic [11:0] c;
      col = t - H0;
      row = l - V0;
      c = 12'h000;
      if (col >= 0 && col < HA && row >= 0 && row < VA) begin
        c = pix_color(mode, col, row);
        if (push) begin
          exp_q.push_back({10'(col), 10'(row), c});
          sum_exp = sum_exp + 16'(c);
        end
      end
      tick((t < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1, c);
    end
  endtask

  task automatic run_frame(input int mode, input bit push, input int stretch_line);
    sum_exp = '0;
    for (int l = 0; l < VT; l++) run_line(l, mode, push, (l == stretch_line) ? 1 : 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, {28'd0, locked, pix_valid, frame_start, timing_err}, 32'd0);
    chk({tag, "_xy"}, {12'd0, x, y}, 32'd0);
    chk({tag, "_pix_rgb"}, 32'(pix_rgb), 32'd0);
    chk({tag, "_lens"}, {12'd0, line_len, frame_lines}, 32'd0);
    chk({tag, "_frame_sum"}, 32'(frame_sum), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; p_tick = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = '0; sum_exp = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Clean timing: MEASURE after the first vsync fall, LOCKED at the second.
    run_frame(1, 1'b0, -1);
    chk("t1_unlocked_first_frame", 32'(locked), 32'd0);
    run_frame(2, 1'b1, -1);
    s2 = sum_exp;
    chk("t1_locked", 32'(locked), 32'd1);
    chk("t1_line_len", 32'(line_len), 32'(HT));
    chk("t1_frame_lines", 32'(frame_lines), 32'(VT));
    chk("t1_pix_count", 32'(pv_cnt), 32'(HA * VA));
    run_frame(1, 1'b1, -1);
    s3 = sum_exp;
    chk("t1_frame_start", 32'(fs_cnt), 32'd1);
    chk("t1_no_timing_err", 32'(err_cnt), 32'd0);
    chk("t1_frame_sum_001", 32'(frame_sum), 32'(exp_sum(s2)));
    chk("t1_pix_count_2frames", 32'(pv_cnt), 32'(2 * HA * VA));

    // One back-porch line stretched by a tick.
    for (int l = 0; l <= 3; l++) run_line(l, 1, 1'b0, (l == 3) ? 1 : 0);
    chk("t2_frame_sum_wrap", 32'(frame_sum), 32'(exp_sum(s3)));
    chk("t2_no_err_before_fall", 32'(err_cnt), 32'd0);
    chk("t2_locked_before_fall", 32'(locked), 32'd1);
    run_line(4, 1, 1'b0, 0);
    chk("t2_err_pulse", 32'(err_cnt), 32'd1);
    chk("t2_line_len_long", 32'(line_len), 32'(HT + 1));
    chk("t2_unlocked", 32'(locked), 32'd0);
    for (int l = 5; l < VT; l++) run_line(l, 1, 1'b0, 0);
    run_frame(1, 1'b0, -1);
    chk("t2_no_early_relock", 32'(locked), 32'd0);

    // Single red pixel at (0,0).
    pv0 = pv_cnt; red0 = red_cnt;
    run_frame(0, 1'b1, -1);
    s6 = sum_exp;
    chk("t3_relocked", 32'(locked), 32'd1);
    chk("t3_pix_count", 32'(pv_cnt - pv0), 32'(HA * VA));
    chk("t3_red_count", 32'(red_cnt - red0), 32'd1);
    chk("t3_frame_start_total", 32'(fs_cnt), 32'd2);
    chk("t3_err_total", 32'(err_cnt), 32'd1);

    // hsync stuck high: saturating hcnt times out.
    sum_exp = '0;
    for (int l = 0; l <= 6; l++) run_line(l, 1, 1'b1, 0);
    chk("t4_frame_sum_red", 32'(frame_sum), 32'(exp_sum(s6)));
    repeat (1024 - HT - 1) tick(1'b1, 1'b1, 12'h000);
    chk("t4_no_err_before_sat", 32'(err_cnt), 32'd1);
    chk("t4_locked_before_sat", 32'(locked), 32'd1);
    tick(1'b1, 1'b1, 12'h000);
    chk("t4_err_at_sat", 32'(err_cnt), 32'd2);
    chk("t4_unlocked", 32'(locked), 32'd0);
    repeat (20) tick(1'b1, 1'b1, 12'h000);
    chk("t4_single_err", 32'(err_cnt), 32'd2);
    run_frame(1, 1'b0, -1);
    chk("t4_search_one_fall", 32'(locked), 32'd0);
    run_frame(1, 1'b1, -1);
    chk("t4_relocked", 32'(locked), 32'd1);

    // Asynchronous reset mid-frame.
    for (int l = 0; l <= 6; l++) run_line(l, 1, 1'b1, 0);
    chk("t5_locked_before_reset", 32'(locked), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t5_async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1, 1'b0, -1);
    chk("t5_unlocked_one_fall", 32'(locked), 32'd0);
    run_frame(1, 1'b1, -1);
    chk("t5_relocked", 32'(locked), 32'd1);
    chk("t5_frame_lines", 32'(frame_lines), 32'(VT));
    chk("t5_err_total", 32'(err_cnt), 32'd2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
